// File: rtl/multicycle_core_if.sv
// Instruction and data memory buses of multicycle_core; the core drives the master modport.
interface multicycle_core_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [31:0]     imem_addr_o;
    logic [31:0]     imem_rdata_i;
    logic            imem_ready_i;
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [31:0]     dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic [XLEN-1:0] dmem_rdata_i;
    logic            dmem_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rdata_i, imem_ready_i,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rdata_i, imem_ready_i,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_ready_i
    );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle RV-subset core (add/sub/and/or/addi/lw/sw/beq) with FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional multiplier: define MULTICYCLE_CORE_MUL_EN to decode and execute mul.
module multicycle_core #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    multicycle_core_if.master bus,
    output logic [31:0]       pc_o,
    output logic              retire_o,
    output logic              halt_o
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [31:0]     r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_regs [32];
    logic [XLEN-1:0] r_rs1Val;
    logic [XLEN-1:0] r_rs2Val;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_load;

    logic [6:0]      w_opcode;
    logic [6:0]      w_funct7;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_isRtype;
    logic            w_isLoad;
    logic            w_isStore;
    logic            w_isBranch;
    logic            w_legal;
    logic [XLEN-1:0] w_immI;
    logic [XLEN-1:0] w_immS;
    logic [XLEN-1:0] w_immB;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1Data;
    logic [XLEN-1:0] w_rs2Data;
    logic [XLEN-1:0] w_alu;
    logic [31:0]     w_pcPlus4;
    logic [31:0]     w_branchTarget;
    logic            w_taken;

    assign w_opcode   = r_instr[6:0];
    assign w_rd       = r_instr[11:7];
    assign w_funct3   = r_instr[14:12];
    assign w_rs1      = r_instr[19:15];
    assign w_rs2      = r_instr[24:20];
    assign w_funct7   = r_instr[31:25];
    assign w_isRtype  = (w_opcode == OP_RTYPE);
    assign w_isLoad   = (w_opcode == OP_LOAD);
    assign w_isStore  = (w_opcode == OP_STORE);
    assign w_isBranch = (w_opcode == OP_BRANCH);

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case ({w_funct7, w_funct3})
                    {7'b0000000, 3'b000},
                    {7'b0100000, 3'b000},
                    {7'b0000000, 3'b111},
                    {7'b0000000, 3'b110}: w_legal = 1'b1;
`ifdef MULTICYCLE_CORE_MUL_EN
                    {7'b0000001, 3'b000}: w_legal = 1'b1;
`endif
                    default:              w_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_BRANCH: w_legal = (w_funct3 == 3'b000);
            OP_LOAD, OP_STORE:  w_legal = (w_funct3 == 3'b010);
            default:            w_legal = 1'b0;
        endcase
    end

    // The B immediate holds offset bits [12:1]; EXEC restores the implicit zero LSB.
    assign w_immI = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_immS = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_immB = {{(XLEN-12){r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8]};
    assign w_imm  = w_isStore ? w_immS : (w_isBranch ? w_immB : w_immI);

    assign w_rs1Data = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2Data = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

    always_comb begin
        w_alu = r_rs1Val + r_imm;
        if (w_isRtype) begin
            case (w_funct3)
                3'b111:  w_alu = r_rs1Val & r_rs2Val;
                3'b110:  w_alu = r_rs1Val | r_rs2Val;
                default: begin
                    if (w_funct7[5]) begin
                        w_alu = r_rs1Val - r_rs2Val;
`ifdef MULTICYCLE_CORE_MUL_EN
                    end else if (w_funct7[0]) begin
                        w_alu = r_rs1Val * r_rs2Val;
`endif
                    end else begin
                        w_alu = r_rs1Val + r_rs2Val;
                    end
                end
            endcase
        end
    end

    assign w_pcPlus4      = r_pc + 32'd4;
    assign w_branchTarget = r_pc + {r_imm[30:0], 1'b0};
    assign w_taken        = (r_rs1Val == r_rs2Val);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState      = r_state;
        bus.imem_req_o   = 1'b0;
        bus.dmem_req_o   = 1'b0;
        bus.dmem_we_o    = 1'b0;
        retire_o         = 1'b0;
        halt_o           = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_nextState = FETCH;
            end
            FETCH: begin
                bus.imem_req_o = 1'b1;
                if (bus.imem_ready_i) w_nextState = DECODE;
            end
            DECODE: begin
                w_nextState = w_legal ? EXEC : HALT;
            end
            EXEC: begin
                if (w_isBranch) begin
                    retire_o    = 1'b1;
                    w_nextState = FETCH;
                end else if (w_isLoad || w_isStore) begin
                    w_nextState = MEM;
                end else begin
                    w_nextState = WB;
                end
            end
            MEM: begin
                bus.dmem_req_o = 1'b1;
                bus.dmem_we_o  = w_isStore;
                if (bus.dmem_ready_i) begin
                    retire_o    = w_isStore;
                    w_nextState = w_isStore ? FETCH : WB;
                end
            end
            WB: begin
                retire_o    = 1'b1;
                w_nextState = FETCH;
            end
            HALT: begin
                halt_o = 1'b1;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Every architectural update is gated by state, so a reset mid-access drops any pending result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_rs1Val <= '0;
            r_rs2Val <= '0;
            r_imm    <= '0;
            r_alu    <= '0;
            r_load   <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_ready_i) r_instr <= bus.imem_rdata_i;
                end
                DECODE: begin
                    r_rs1Val <= w_rs1Data;
                    r_rs2Val <= w_rs2Data;
                    r_imm    <= w_imm;
                end
                EXEC: begin
                    r_alu <= w_alu;
                    if (w_isBranch) r_pc <= w_taken ? w_branchTarget : w_pcPlus4;
                end
                MEM: begin
                    if (bus.dmem_ready_i) begin
                        if (w_isStore) r_pc <= w_pcPlus4;
                        else           r_load <= bus.dmem_rdata_i;
                    end
                end
                WB: begin
                    r_pc <= w_pcPlus4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (r_state == WB && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_isLoad ? r_load : r_alu;
        end
    end

    assign bus.imem_addr_o  = r_pc;
    assign bus.dmem_addr_o  = r_alu[31:0];
    assign bus.dmem_wdata_o = r_rs2Val;
    assign pc_o             = r_pc;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: XLEN=32 core with wait-state memories plus a zero-wait XLEN=64 twin.
// Expectations for mul follow MULTICYCLE_CORE_MUL_EN.
module tb_multicycle_core;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;

    multicycle_core_if #(.XLEN(32)) bus32();
    multicycle_core_if #(.XLEN(64)) bus64();

    logic [31:0] pc32, pc64;
    logic        retire32, retire64, halt32, halt64;

    multicycle_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus32),
        .pc_o(pc32), .retire_o(retire32), .halt_o(halt32)
    );

    multicycle_core #(.XLEN(64), .RESET_PC(32'h0)) dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus64),
        .pc_o(pc64), .retire_o(retire64), .halt_o(halt64)
    );

    always #5 clk = ~clk;

    logic [31:0] imem   [0:63];
    logic [31:0] dmem32 [0:15];
    logic [63:0] dmem64 [0:15];
    int          imemWait  = 0;
    int          dmemWait  = 0;
    logic        imemPulse = 1'b0;
    int          imemCnt   = 0;
    int          dmemCnt   = 0;

    assign bus32.imem_ready_i = (bus32.imem_req_o && imemCnt >= imemWait) || imemPulse;
    assign bus32.imem_rdata_i = imem[bus32.imem_addr_o[7:2]];
    assign bus32.dmem_ready_i = bus32.dmem_req_o && dmemCnt >= dmemWait;
    assign bus32.dmem_rdata_i = dmem32[bus32.dmem_addr_o[5:2]];
    assign bus64.imem_ready_i = bus64.imem_req_o;
    assign bus64.imem_rdata_i = imem[bus64.imem_addr_o[7:2]];
    assign bus64.dmem_ready_i = bus64.dmem_req_o;
    assign bus64.dmem_rdata_i = dmem64[bus64.dmem_addr_o[5:2]];

    // Memory models, store log and bus-protocol monitors
    int          storeCnt = 0, store64Cnt = 0, retireCnt = 0;
    logic [31:0] storeAddr [0:7];
    logic [31:0] storeData [0:7];
    logic [63:0] lastStore64 = '0;
    int          dWaitCycles = 0, dStableErr = 0, iStableErr = 0, weErr = 0, overlapErr = 0;
    logic        dWaiting = 1'b0, iWaiting = 1'b0;
    logic [31:0] dHoldAddr, dHoldData, iHoldAddr;
    logic        dHoldWe;

    always @(posedge clk) begin
        if (bus32.imem_req_o && !bus32.imem_ready_i) imemCnt <= imemCnt + 1;
        else                                         imemCnt <= 0;
        if (bus32.dmem_req_o && !bus32.dmem_ready_i) dmemCnt <= dmemCnt + 1;
        else                                         dmemCnt <= 0;
        if (retire32) retireCnt <= retireCnt + 1;
        if (bus32.dmem_req_o && bus32.dmem_ready_i && bus32.dmem_we_o) begin
            storeAddr[storeCnt % 8]         <= bus32.dmem_addr_o;
            storeData[storeCnt % 8]         <= bus32.dmem_wdata_o;
            dmem32[bus32.dmem_addr_o[5:2]]  <= bus32.dmem_wdata_o;
            storeCnt                        <= storeCnt + 1;
        end
        if (bus64.dmem_req_o && bus64.dmem_ready_i && bus64.dmem_we_o) begin
            dmem64[bus64.dmem_addr_o[5:2]] <= bus64.dmem_wdata_o;
            lastStore64                    <= bus64.dmem_wdata_o;
            store64Cnt                     <= store64Cnt + 1;
        end
        if (bus32.dmem_we_o && !bus32.dmem_req_o) weErr <= weErr + 1;
        if (bus32.imem_req_o && bus32.dmem_req_o) overlapErr <= overlapErr + 1;
        if (bus32.dmem_req_o && !bus32.dmem_ready_i) begin
            dWaitCycles <= dWaitCycles + 1;
            if (dWaiting && (dHoldAddr != bus32.dmem_addr_o || dHoldData != bus32.dmem_wdata_o ||
                             dHoldWe != bus32.dmem_we_o))
                dStableErr <= dStableErr + 1;
            dWaiting  <= 1'b1;
            dHoldAddr <= bus32.dmem_addr_o;
            dHoldData <= bus32.dmem_wdata_o;
            dHoldWe   <= bus32.dmem_we_o;
        end else begin
            dWaiting <= 1'b0;
        end
        if (bus32.imem_req_o && !bus32.imem_ready_i) begin
            if (iWaiting && iHoldAddr != bus32.imem_addr_o) iStableErr <= iStableErr + 1;
            iWaiting  <= 1'b1;
            iHoldAddr <= bus32.imem_addr_o;
        end else begin
            iWaiting <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] off, input logic [4:0] rs1, input logic [4:0] rs2);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    task automatic resetCore();
        rst       = 1'b1;
        start     = 1'b0;
        imemPulse = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clearImem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic startCore();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitHalt(input int maxCycles);
        int n = 0;
        while (!halt32 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt reached", {63'd0, halt32}, 64'd1);
    endtask

    typedef struct {
        logic [6:0]  f7;
        logic [2:0]  f3;
        bit          useImm;
        logic [11:0] a;
        logic [11:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [8];

    // Program: addi x1,x0,a; addi x2,x0,b; op x3,x1,x2 (or addi x3,x1,b); sw x3,0(x0); illegal
    task automatic applyStimulus(input vec_t v);
        resetCore();
        clearImem();
        imem[0] = encI(v.a, 5'd0, 3'b000, 5'd1, OP_ADDI);
        imem[1] = encI(v.b, 5'd0, 3'b000, 5'd2, OP_ADDI);
        imem[2] = v.useImm ? encI(v.b, 5'd1, 3'b000, 5'd3, OP_ADDI) : encR(v.f7, 5'd2, 5'd1, v.f3, 5'd3);
        imem[3] = encS(12'd0, 5'd3, 5'd0);
        startCore();
        waitHalt(100);
    endtask

    task automatic runBranch(input string name, input logic [4:0] rs2, input logic [31:0] expNext);
        int n;
        resetCore();
        clearImem();
        imem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, OP_ADDI);
        imem[1] = encI(12'd7, 5'd0, 3'b000, 5'd2, OP_ADDI);
        imem[2] = encI(12'd0, 5'd0, 3'b000, 5'd0, OP_ADDI);
        imem[3] = encI(12'd0, 5'd0, 3'b000, 5'd0, OP_ADDI);
        imem[4] = encB(-13'sd8, 5'd1, rs2);
        startCore();
        n = 0;
        while (!(bus32.imem_req_o && bus32.imem_addr_o == 32'h10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " fetch at 0x10"}, bus32.imem_addr_o, 32'h10);
        n = 1;
        while (!retire32 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency"}, n, 3);
        @(negedge clk);
        checkOutput({name, " next fetch addr"}, bus32.imem_addr_o, expNext);
        checkOutput({name, " next fetch req"}, {63'd0, bus32.imem_req_o}, 64'd1);
    endtask

    initial begin
        int n, r, baseS, baseR, baseW, expStores, expRetire;
        logic [31:0] expPc;

        vecs[0] = '{7'h00, 3'b000, 1'b0, 12'd5,    12'd7,    64'd12};
        vecs[1] = '{7'h20, 3'b000, 1'b0, 12'd5,    12'd7,    64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{7'h00, 3'b111, 1'b0, 12'd12,   12'd10,   64'd8};
        vecs[3] = '{7'h00, 3'b110, 1'b0, 12'd12,   12'd3,    64'd15};
        vecs[4] = '{7'h00, 3'b000, 1'b1, 12'hFFF,  12'd1,    64'd0};
        vecs[5] = '{7'h20, 3'b000, 1'b0, 12'h800,  12'h7FF,  64'hFFFF_FFFF_FFFF_F001};
        vecs[6] = '{7'h00, 3'b000, 1'b0, 12'h7FF,  12'h7FF,  64'd4094};
        vecs[7] = '{7'h00, 3'b000, 1'b0, 12'd100,  12'hFFD,  64'd97};

        clearImem();
        resetCore();
        checkOutput("reset pc", pc32, 32'h0);
        checkOutput("reset halt", {63'd0, halt32}, 64'd0);
        checkOutput("reset retire", {63'd0, retire32}, 64'd0);
        checkOutput("reset imem_req", {63'd0, bus32.imem_req_o}, 64'd0);
        checkOutput("reset dmem_req", {63'd0, bus32.dmem_req_o}, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("idle without start", {63'd0, bus32.imem_req_o}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d store32", i), storeData[(storeCnt - 1) % 8], vecs[i].exp[31:0]);
            checkOutput($sformatf("vec%0d store64", i), lastStore64, vecs[i].exp);
            checkOutput($sformatf("vec%0d halt pc", i), pc32, 32'h10);
        end

        // Three-instruction latency, then a store/load round trip through a 3-wait data memory
        resetCore();
        clearImem();
        imem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, OP_ADDI);
        imem[1] = encI(12'd7, 5'd0, 3'b000, 5'd2, OP_ADDI);
        imem[2] = encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        imem[3] = encS(12'd0, 5'd3, 5'd0);
        imem[4] = encI(12'd0, 5'd0, 3'b010, 5'd4, OP_LOAD);
        imem[5] = encS(12'd4, 5'd4, 5'd0);
        dmemWait = 3;
        baseS = storeCnt;
        baseR = retireCnt;
        baseW = dWaitCycles;
        startCore();
        checkOutput("first fetch req", {63'd0, bus32.imem_req_o}, 64'd1);
        checkOutput("first fetch addr", bus32.imem_addr_o, 32'h0);
        n = 1;
        r = 0;
        while (r < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (retire32) r++;
        end
        checkOutput("three instr cycles", n, 12);
        waitHalt(200);
        checkOutput("store count", storeCnt - baseS, 2);
        checkOutput("sw addr", storeAddr[baseS % 8], 32'h0);
        checkOutput("sw data", storeData[baseS % 8], 32'd12);
        checkOutput("lw-sw addr", storeAddr[(baseS + 1) % 8], 32'h4);
        checkOutput("lw-sw data", storeData[(baseS + 1) % 8], 32'd12);
        checkOutput("retire count", retireCnt - baseR, 6);
        checkOutput("dmem wait cycles", dWaitCycles - baseW, 9);
        checkOutput("dmem stable", dStableErr, 0);
        checkOutput("halt pc", pc32, 32'h18);
        checkOutput("x64 halt", {63'd0, halt64}, 64'd1);
        checkOutput("x64 lw-sw data", lastStore64, 64'd12);
        checkOutput("x64 halt pc", pc64, 32'h18);
        startCore();
        repeat (3) @(negedge clk);
        checkOutput("halt ignores start", {63'd0, halt32}, 64'd1);
        checkOutput("halt no fetch", {63'd0, bus32.imem_req_o}, 64'd0);
        checkOutput("halt no retire", retireCnt - baseR, 6);
        dmemWait = 0;

        // Writes to x0 are discarded
        resetCore();
        clearImem();
        imem[0] = encI(12'd9, 5'd0, 3'b000, 5'd0, OP_ADDI);
        imem[1] = encR(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);
        imem[2] = encS(12'd0, 5'd5, 5'd0);
        startCore();
        waitHalt(100);
        checkOutput("x0 store", storeData[(storeCnt - 1) % 8], 32'd0);

        runBranch("beq taken", 5'd1, 32'h08);
        runBranch("beq not taken", 5'd2, 32'h14);

        // mul x6,x1,x2 with 5 and 7
        resetCore();
        clearImem();
        imem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, OP_ADDI);
        imem[1] = encI(12'd7, 5'd0, 3'b000, 5'd2, OP_ADDI);
        imem[2] = encR(7'h01, 5'd2, 5'd1, 3'b000, 5'd6);
        imem[3] = encS(12'd0, 5'd6, 5'd0);
        baseS = storeCnt;
        baseR = retireCnt;
        startCore();
        waitHalt(100);
`ifdef MULTICYCLE_CORE_MUL_EN
        expStores = 1;
        expRetire = 4;
        expPc     = 32'h10;
        checkOutput("mul result", storeData[baseS % 8], 32'd35);
        checkOutput("x64 mul result", lastStore64, 64'd35);
`else
        expStores = 0;
        expRetire = 2;
        expPc     = 32'h08;
`endif
        checkOutput("mul stores", storeCnt - baseS, expStores);
        checkOutput("mul retires", retireCnt - baseR, expRetire);
        checkOutput("mul pc", pc32, expPc);

        // Reset while a fetch is stalled, then a stray ready pulse
        resetCore();
        clearImem();
        imem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, OP_ADDI);
        imem[1] = encI(12'd7, 5'd0, 3'b000, 5'd2, OP_ADDI);
        imem[2] = encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        imem[3] = encS(12'd0, 5'd3, 5'd0);
        baseS = storeCnt;
        baseR = retireCnt;
        startCore();
        n = 0;
        while (retireCnt - baseR < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        imemWait = 5;
        repeat (2) @(negedge clk);
        checkOutput("stalled fetch pc", pc32, 32'h08);
        checkOutput("stalled fetch req", {63'd0, bus32.imem_req_o}, 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset pc", pc32, 32'h0);
        checkOutput("async reset req", {63'd0, bus32.imem_req_o}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        imemPulse = 1'b1;
        @(negedge clk);
        imemPulse = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("late ready idle", {63'd0, bus32.imem_req_o}, 64'd0);
        checkOutput("late ready pc", pc32, 32'h0);
        checkOutput("late ready retire", retireCnt - baseR, 2);
        checkOutput("late ready stores", storeCnt - baseS, 0);
        checkOutput("imem stable", iStableErr, 0);
        imemWait = 0;

        // Register file is cleared by reset: x1 held 5 before it
        clearImem();
        imem[0] = encS(12'd0, 5'd1, 5'd0);
        startCore();
        waitHalt(100);
        checkOutput("regfile cleared", storeData[(storeCnt - 1) % 8], 32'd0);
        checkOutput("x64 regfile cleared", lastStore64, 64'd0);

        checkOutput("dmem_we outside MEM", weErr, 0);
        checkOutput("imem/dmem overlap", overlapErr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
